sa_wb_collector: RTL and testbench

- Downstream of the systolic-array top. Captures the quantized N-byte result rows it emits on `wen_n`/`waddr`/`data_out`.
- Optionally applies per-byte ReLU and buffers rows in a small FIFO.
- Drains the FIFO into the shared result SRAM through a req/gnt arbiter port.
- Counts committed rows and pulses `done` once the expected row count has been written to SRAM.

---
 rtl/sa_wb_collector.sv | 170 +++++++++++++++++
 tb/tb_sa_wb_collector.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_wb_collector.sv
// Result-row collector: captures quantized rows from the systolic array, optionally applies ReLU,
// buffers them in a FIFO and drains them into the shared result SRAM through a req/gnt port.
module sa_wb_collector #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     cfg_relu_en,
    input  logic [AW-1:0]            cfg_base_addr,
    input  logic [15:0]              cfg_exp_rows,
    input  logic                     in_wen_n,
    input  logic [AW-1:0]            in_waddr,
    input  logic [N*8-1:0]           in_data,
    output logic                     sram_req,
    input  logic                     sram_gnt,
    output logic                     sram_wen_n,
    output logic [AW-1:0]            sram_waddr,
    output logic [N*8-1:0]           sram_wdata,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy,
    output logic                     done,
    output logic                     err_overflow,
    output logic                     err_extra
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned DW = N * 8;
    localparam int unsigned EW = AW + DW;

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e          state_q, state_d;
    logic            relu_en_q;
    logic [AW-1:0]   base_q;
    logic [15:0]     exp_q;
    logic [15:0]     acc_q, acc_d;
    logic [15:0]     wr_q, wr_d;
    logic            ovf_q, ovf_d;
    logic            extra_q, extra_d;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [LW-1:0]   level_q, level_d;

    logic            wen_n_q;
    logic [AW-1:0]   waddr_q;
    logic [DW-1:0]   wdata_q;

    logic            row_valid, fifo_empty, fifo_full;
    logic            push_req, push, pop, drop;
    logic [EW-1:0]   push_entry;

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] d, input logic en);
        logic [DW-1:0] r;
        r = d;
        for (int i = 0; i < int'(N); i++) begin
            if (en && d[8*i+7]) r[8*i +: 8] = 8'h00;
        end
        return r;
    endfunction

    assign row_valid  = !in_wen_n;
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(DEPTH));
    // Rows beyond the expected count are not pushed; they flag err_extra instead.
    assign push_req   = (state_q == StRun) && row_valid && (acc_q != exp_q);
    assign pop        = !fifo_empty && sram_gnt;
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;
    assign push_entry = {base_q + in_waddr, relu(in_data, relu_en_q)};
    assign level_d    = level_q + LW'(push) - LW'(pop);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        wr_d    = wr_q;
        ovf_d   = ovf_q;
        extra_d = extra_q;
        if (push_req) acc_d = acc_q + 16'd1;
        if (pop)      wr_d  = wr_q + 16'd1;
        if (drop)     ovf_d = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    acc_d   = '0;
                    wr_d    = '0;
                    ovf_d   = 1'b0;
                    extra_d = 1'b0;
                end
            end
            StRun: begin
                if (acc_d == exp_q) state_d = StFlush;
            end
            StFlush: begin
                // A dropped row is never written, so an overflowed job parks here until reset.
                if (wr_q == exp_q && fifo_empty && wen_n_q) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (row_valid && !push_req) extra_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            relu_en_q <= 1'b0;
            base_q    <= '0;
            exp_q     <= '0;
            acc_q     <= '0;
            wr_q      <= '0;
            ovf_q     <= 1'b0;
            extra_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            wr_q    <= wr_d;
            ovf_q   <= ovf_d;
            extra_q <= extra_d;
            if (state_q == StIdle && start) begin
                relu_en_q <= cfg_relu_en;
                base_q    <= cfg_base_addr;
                exp_q     <= cfg_exp_rows;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_n_q <= 1'b1;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_n_q <= !pop;
            if (pop) {waddr_q, wdata_q} <= mem_q[rptr_q];
        end
    end

    assign sram_req     = !fifo_empty;
    assign sram_wen_n   = wen_n_q;
    assign sram_waddr   = waddr_q;
    assign sram_wdata   = wdata_q;
    assign fifo_level   = level_q;
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign err_overflow = ovf_q;
    assign err_extra    = extra_q;

endmodule

// File: tb/tb_sa_wb_collector.sv
// Directed bench for sa_wb_collector: fixed vectors with hand-computed expected SRAM traffic.
module tb_sa_wb_collector;

    localparam int N     = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 13;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              cfg_relu_en = 1'b0;
    logic [AW-1:0]     cfg_base_addr = '0;
    logic [15:0]       cfg_exp_rows = '0;
    logic              in_wen_n = 1'b1;
    logic [AW-1:0]     in_waddr = '0;
    logic [N*8-1:0]    in_data = '0;
    logic              sram_req;
    logic              sram_gnt = 1'b0;
    logic              sram_wen_n;
    logic [AW-1:0]     sram_waddr;
    logic [N*8-1:0]    sram_wdata;
    logic [LW-1:0]     fifo_level;
    logic              busy, done, err_overflow, err_extra;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [AW-1:0]  wr_addr_q [$];
    logic [N*8-1:0] wr_data_q [$];
    int             done_cnt = 0;

    sa_wb_collector #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_relu_en   (cfg_relu_en),
        .cfg_base_addr (cfg_base_addr),
        .cfg_exp_rows  (cfg_exp_rows),
        .in_wen_n      (in_wen_n),
        .in_waddr      (in_waddr),
        .in_data       (in_data),
        .sram_req      (sram_req),
        .sram_gnt      (sram_gnt),
        .sram_wen_n    (sram_wen_n),
        .sram_waddr    (sram_waddr),
        .sram_wdata    (sram_wdata),
        .fifo_level    (fifo_level),
        .busy          (busy),
        .done          (done),
        .err_overflow  (err_overflow),
        .err_extra     (err_extra)
    );

    always #5 clk = ~clk;

    // Record every SRAM strobe and done pulse mid-cycle.
    always @(negedge clk) begin
        if (rst_n && !sram_wen_n) begin
            wr_addr_q.push_back(sram_waddr);
            wr_data_q.push_back(sram_wdata);
        end
        if (rst_n && done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic relu, input logic [AW-1:0] base, input logic [15:0] rows);
        cfg_relu_en   = relu;
        cfg_base_addr = base;
        cfg_exp_rows  = rows;
        start         = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_row(input logic [AW-1:0] addr, input logic [N*8-1:0] data);
        in_wen_n = 1'b0;
        in_waddr = addr;
        in_data  = data;
        tick();
        in_wen_n = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [63:0] rep(input int i);
        return 64'(i) * 64'h0101_0101_0101_0101;
    endfunction

    initial begin
        int wb;
        int db;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_wen_n", 64'(sram_wen_n), 64'd1);
        check("rst_waddr", 64'(sram_waddr), 64'd0);
        check("rst_wdata", sram_wdata, 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_req", 64'(sram_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_errs", {62'd0, err_overflow, err_extra}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic job, relu off, grant tied high
        sram_gnt = 1'b1;
        wb = wr_addr_q.size();
        db = done_cnt;
        start_job(1'b0, 13'h100, 16'd3);
        check("basic_busy", 64'(busy), 64'd1);
        send_row(13'd0,  64'h0102_0304_0506_0708);
        send_row(13'd8,  64'h1112_1314_1516_1718);
        send_row(13'd16, 64'h2122_2324_2526_2728);
        wait_done("basic_done", 40);
        tick();
        check("basic_busy_fall", 64'(busy), 64'd0);
        check("basic_done_low", 64'(done), 64'd0);
        repeat (3) tick();
        check("basic_done_cnt", 64'(done_cnt - db), 64'd1);
        check("basic_nwr", 64'(wr_addr_q.size() - wb), 64'd3);
        check("basic_a0", 64'(wr_addr_q[wb]),   64'h100);
        check("basic_a1", 64'(wr_addr_q[wb+1]), 64'h108);
        check("basic_a2", 64'(wr_addr_q[wb+2]), 64'h110);
        check("basic_d0", wr_data_q[wb],   64'h0102_0304_0506_0708);
        check("basic_d2", wr_data_q[wb+2], 64'h2122_2324_2526_2728);

        // ReLU: byte0 = 0x80 ... byte7 = 0xF0
        wb = wr_addr_q.size();
        start_job(1'b1, 13'h0, 16'd1);
        send_row(13'h20, 64'hF010_9C01_007F_FF80);
        wait_done("relu_done", 30);
        tick();
        check("relu_nwr", 64'(wr_addr_q.size() - wb), 64'd1);
        check("relu_addr", 64'(wr_addr_q[wb]), 64'h20);
        check("relu_data", wr_data_q[wb], 64'h0010_0001_007F_0000);

        // Backpressure: 9 rows into an 8-deep FIFO with no grant
        sram_gnt = 1'b0;
        wb = wr_addr_q.size();
        db = done_cnt;
        start_job(1'b0, 13'h0, 16'd9);
        for (int i = 1; i <= 9; i++) send_row(13'(i), rep(i));
        check("ovf_level", 64'(fifo_level), 64'd8);
        check("ovf_flag", 64'(err_overflow), 64'd1);
        check("ovf_req", 64'(sram_req), 64'd1);
        check("ovf_no_wr", 64'(wr_addr_q.size() - wb), 64'd0);
        sram_gnt = 1'b1;
        repeat (15) tick();
        check("ovf_nwr", 64'(wr_addr_q.size() - wb), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check("ovf_addr", 64'(wr_addr_q[wb+i]), 64'(i + 1));
            check("ovf_data", wr_data_q[wb+i], rep(i + 1));
        end
        check("ovf_no_done", 64'(done_cnt - db), 64'd0);
        check("ovf_stuck_busy", 64'(busy), 64'd1);
        sram_gnt = 1'b0;
        pulse_reset();
        check("ovf_rst_busy", 64'(busy), 64'd0);
        check("ovf_rst_flag", 64'(err_overflow), 64'd0);

        // Full FIFO with simultaneous push and pop
        wb = wr_addr_q.size();
        db = done_cnt;
        start_job(1'b0, 13'h0, 16'd9);
        for (int i = 1; i <= 8; i++) send_row(13'(i), rep(i));
        check("fp_full", 64'(fifo_level), 64'd8);
        sram_gnt = 1'b1;
        send_row(13'd9, rep(9));
        check("fp_level", 64'(fifo_level), 64'd8);
        check("fp_no_ovf", 64'(err_overflow), 64'd0);
        wait_done("fp_done", 40);
        tick();
        check("fp_nwr", 64'(wr_addr_q.size() - wb), 64'd9);
        for (int i = 0; i < 9; i++) check("fp_data", wr_data_q[wb+i], rep(i + 1));
        check("fp_done_cnt", 64'(done_cnt - db), 64'd1);

        // exp_rows = 0: done three cycles after start, no writes
        wb = wr_addr_q.size();
        start_job(1'b0, 13'h0, 16'd0);
        check("zero_run", 64'(done), 64'd0);
        tick();
        check("zero_flush", 64'(done), 64'd0);
        tick();
        check("zero_done", 64'(done), 64'd1);
        tick();
        check("zero_idle", 64'(busy), 64'd0);
        check("zero_nwr", 64'(wr_addr_q.size() - wb), 64'd0);

        // Row in IDLE
        send_row(13'd5, rep(5));
        check("idle_extra", 64'(err_extra), 64'd1);
        check("idle_level", 64'(fifo_level), 64'd0);

        // Address wrap: 0x1FF8 + 0x10 -> 0x0008
        wb = wr_addr_q.size();
        start_job(1'b0, 13'h1FF8, 16'd1);
        check("wrap_extra_clr", 64'(err_extra), 64'd0);
        send_row(13'h10, 64'h0A0B_0C0D_0E0F_1011);
        wait_done("wrap_done", 30);
        tick();
        check("wrap_addr", 64'(wr_addr_q[wb]), 64'h0008);
        check("wrap_data", wr_data_q[wb], 64'h0A0B_0C0D_0E0F_1011);

        // Reset mid-job with 4 rows queued
        sram_gnt = 1'b0;
        wb = wr_addr_q.size();
        start_job(1'b0, 13'h0, 16'd6);
        for (int i = 1; i <= 4; i++) send_row(13'(i), rep(i));
        check("mid_level", 64'(fifo_level), 64'd4);
        rst_n = 1'b0;
        #1;
        check("mid_level_rst", 64'(fifo_level), 64'd0);
        check("mid_req_rst", 64'(sram_req), 64'd0);
        check("mid_busy_rst", 64'(busy), 64'd0);
        check("mid_waddr_rst", 64'(sram_waddr), 64'd0);
        check("mid_wdata_rst", sram_wdata, 64'd0);
        sram_gnt = 1'b1;
        tick();
        tick();
        check("mid_wen_rst", 64'(sram_wen_n), 64'd1);
        rst_n = 1'b1;
        repeat (3) tick();
        check("mid_no_wr", 64'(wr_addr_q.size() - wb), 64'd0);
        db = done_cnt;
        start_job(1'b0, 13'h40, 16'd2);
        send_row(13'd0, rep(7));
        send_row(13'd1, rep(8));
        wait_done("mid_done", 30);
        tick();
        check("mid_nwr", 64'(wr_addr_q.size() - wb), 64'd2);
        check("mid_a0", 64'(wr_addr_q[wb]), 64'h40);
        check("mid_a1", 64'(wr_addr_q[wb+1]), 64'h41);
        check("mid_d1", wr_data_q[wb+1], rep(8));
        check("mid_done_cnt", 64'(done_cnt - db), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
